mem_client_arbiter: RTL

- Shares one memory command/write/read interface between num_clients requesters, e.g. the port FIFO arbiter plus a DMA or test-pattern engine.
- Sits in the clk_mem domain, between the async FIFOs and the DDR controller.
- Selects commands round-robin and forwards write data for the granted client.
- Routes in-order read returns to the issuing client using an internal tag FIFO.

---
 rtl/mem_client_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_client_arbiter.sv
// Round-robin arbiter sharing one memory command/write/read port among several clients.
// Read returns are steered back to their issuer through an in-order tag FIFO.
module mem_client_arbiter #(
    parameter int num_clients     = 2,
    parameter int mem_width       = 32,
    parameter int max_outstanding = 4
) (
    input  logic                                  clk_mem,
    input  logic                                  reset,
    input  logic [num_clients-1:0]                cli_cmd_valid,
    output logic [num_clients-1:0]                cli_cmd_ready,
    input  logic [num_clients-1:0][31:0]          cli_cmd_address,
    input  logic [num_clients-1:0][31:0]          cli_cmd_length,
    input  logic [num_clients-1:0]                cli_cmd_read_not_write,
    input  logic [num_clients-1:0]                cli_wr_valid,
    output logic [num_clients-1:0]                cli_wr_ready,
    input  logic [num_clients-1:0][mem_width-1:0] cli_wr_data,
    output logic [num_clients-1:0]                cli_rd_valid,
    input  logic [num_clients-1:0]                cli_rd_ready,
    output logic [mem_width-1:0]                  cli_rd_data,
    output logic                                  mem_cmd_valid,
    input  logic                                  mem_cmd_ready,
    output logic [64:0]                           mem_cmd_data,
    output logic                                  mem_write_valid,
    input  logic                                  mem_write_ready,
    output logic [mem_width-1:0]                  mem_write_data,
    input  logic                                  mem_read_valid,
    output logic                                  mem_read_ready,
    input  logic [mem_width-1:0]                  mem_read_data,
    output logic                                  protocol_error
);

    localparam int cw = (num_clients > 1) ? $clog2(num_clients) : 1;
    localparam int pw = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE_DATA} state_t;

    state_t          state, state_next;
    logic [cw-1:0]   last_grant, winner, cur_client, head_client;
    logic            found, accept;
    logic [31:0]     cur_address, cur_length, wr_remaining, rd_remaining;
    logic            cur_read;
    logic [cw-1:0]   tag_client [max_outstanding];
    logic [31:0]     tag_length [max_outstanding];
    logic [pw-1:0]   tag_wr_ptr, tag_rd_ptr;
    logic [pw:0]     tag_count;
    logic            tag_full, tag_empty, tag_push, tag_pop;
    logic            cmd_fire, wr_fire, rd_fire;

    // Scan from the client after the last grant; reads are skipped while no tag slot is free.
    always_comb begin : arbitrate
        int idx;
        logic [cw-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int i = 1; i <= num_clients; i++) begin
            idx  = (int'(last_grant) + i) % num_clients;
            cand = cw'(idx);
            if (!found && cli_cmd_valid[cand] && !(cli_cmd_read_not_write[cand] && tag_full)) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign accept    = reset && (state == IDLE) && found;
    assign tag_full  = (tag_count == (pw+1)'(max_outstanding));
    assign tag_empty = (tag_count == '0);

    always_ff @(posedge clk_mem) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept && cli_cmd_length[winner] != 32'd0) state_next = ISSUE;
            ISSUE:      if (cmd_fire) state_next = cur_read ? IDLE : WRITE_DATA;
            WRITE_DATA: if (wr_fire && wr_remaining == 32'd1) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Handshake outputs are held low while reset is asserted so no beat slips through the reset edge.
    always_comb begin
        cli_cmd_ready   = '0;
        cli_wr_ready    = '0;
        mem_cmd_valid   = 1'b0;
        mem_write_valid = 1'b0;
        mem_write_data  = '0;
        if (accept) cli_cmd_ready[winner] = 1'b1;
        if (reset && state == ISSUE) mem_cmd_valid = 1'b1;
        if (reset && state == WRITE_DATA) begin
            mem_write_valid          = cli_wr_valid[cur_client];
            cli_wr_ready[cur_client] = mem_write_ready;
            mem_write_data           = cli_wr_data[cur_client];
        end
    end

    assign mem_cmd_data = {cur_address, cur_length, cur_read};
    assign cmd_fire     = mem_cmd_valid && mem_cmd_ready;
    assign wr_fire      = mem_write_valid && mem_write_ready;
    assign tag_push     = cmd_fire && cur_read;

    always_ff @(posedge clk_mem) begin
        if (!reset) begin
            cur_address  <= '0;
            cur_length   <= '0;
            cur_read     <= 1'b0;
            cur_client   <= '0;
            last_grant   <= cw'(num_clients - 1);
            wr_remaining <= '0;
        end else begin
            if (accept) begin
                cur_address <= cli_cmd_address[winner];
                cur_length  <= cli_cmd_length[winner];
                cur_read    <= cli_cmd_read_not_write[winner];
                cur_client  <= winner;
                last_grant  <= winner;
            end
            if (cmd_fire && !cur_read) wr_remaining <= cur_length;
            else if (wr_fire)          wr_remaining <= wr_remaining - 32'd1;
        end
    end

    // Read return routing follows the tag FIFO head, independently of the command state machine.
    assign head_client  = tag_client[tag_rd_ptr];
    assign rd_remaining = tag_length[tag_rd_ptr];
    assign cli_rd_data  = mem_read_data;

    always_comb begin
        cli_rd_valid   = '0;
        mem_read_ready = 1'b0;
        if (reset && !tag_empty) begin
            cli_rd_valid[head_client] = mem_read_valid;
            mem_read_ready            = cli_rd_ready[head_client];
        end
    end

    assign rd_fire = mem_read_valid && mem_read_ready;
    assign tag_pop = rd_fire && (rd_remaining == 32'd1);

    // The head entry's length is counted down in place; a push never targets the head slot.
    always_ff @(posedge clk_mem) begin
        if (!reset) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (tag_push) begin
                tag_client[tag_wr_ptr] <= cur_client;
                tag_length[tag_wr_ptr] <= cur_length;
                tag_wr_ptr <= (tag_wr_ptr == pw'(max_outstanding - 1)) ? '0 : tag_wr_ptr + pw'(1);
            end
            if (tag_pop)
                tag_rd_ptr <= (tag_rd_ptr == pw'(max_outstanding - 1)) ? '0 : tag_rd_ptr + pw'(1);
            else if (rd_fire)
                tag_length[tag_rd_ptr] <= rd_remaining - 32'd1;
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + (pw+1)'(1);
                2'b01:   tag_count <= tag_count - (pw+1)'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clk_mem) begin
        if (!reset)                         protocol_error <= 1'b0;
        else if (mem_read_valid && tag_empty) protocol_error <= 1'b1;
    end

endmodule
